// File: rtl/clock_pkg.sv
// Shared BCD types, range limits, alarm reset values and BCD helpers for the timekeeper.
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [7:0] BCD_00 = 8'h00;
    localparam logic [7:0] BCD_01 = 8'h01;
    localparam logic [7:0] BCD_11 = 8'h11;
    localparam logic [7:0] BCD_12 = 8'h12;
    localparam logic [7:0] BCD_23 = 8'h23;
    localparam logic [7:0] BCD_59 = 8'h59;

    localparam logic [7:0] ALARM_HH_RST_12H = 8'h12;
    localparam logic [7:0] ALARM_HH_RST_24H = 8'h00;
    localparam logic [7:0] ALARM_MM_RST     = 8'h00;

    function automatic logic bcd_ok(input logic [7:0] v);
        bcd_digit_t hi;
        bcd_digit_t lo;
        hi = v[7:4];
        lo = v[3:0];
        return (hi <= 4'd9) && (lo <= 4'd9);
    endfunction

    function automatic logic [7:0] bcd_next(input logic [7:0] v,
                                            input logic [7:0] min_v,
                                            input logic [7:0] max_v);
        bcd_digit_t hi;
        hi = v[7:4] + 4'd1;
        if (v == max_v)
            return min_v;
        else if (v[3:0] == 4'd9)
            return {hi, 4'd0};
        else
            return v + 8'd1;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter MIN..MAX; load has priority over inc. wrap is the
// combinational carry-out for the cycle in which an inc takes MAX back to MIN.
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter logic [7:0] MIN = 8'h00,
    parameter logic [7:0] MAX = 8'h59,
    parameter logic [7:0] RST = MIN
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] q,
    output logic       wrap
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load)
            q_d = load_val;
        else if (inc)
            q_d = bcd_next(q_q, MIN, MAX);
    end

    always_ff @(posedge clk) begin
        if (reset)
            q_q <= RST;
        else
            q_q <= q_d;
    end

    assign q    = q_q;
    assign wrap = inc && !load && (q_q == MAX);

endmodule

// File: rtl/clock_counter_ext.sv
// BCD hh:mm:ss timekeeper (12h/24h build option) with validated load port,
// hh:mm alarm with sticky flag, and a one-cycle day-wrap pulse.
module clock_counter_ext
    import clock_pkg::*;
#(
    parameter bit MODE_24H = 1'b0,
    parameter bit ALARM_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ena,
    input  logic       load_valid,
    input  logic [7:0] load_hh,
    input  logic [7:0] load_mm,
    input  logic [7:0] load_ss,
    input  logic       load_pm,
    output logic       load_ready,
    output logic       load_err,
    input  logic       alarm_set,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_pm,
    input  logic       alarm_ack,
    output logic       pm,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       day_wrap,
    output logic       alarm_hit,
    output logic       alarm_flag
);

    localparam logic [7:0] HH_MIN    = MODE_24H ? BCD_00 : BCD_01;
    localparam logic [7:0] HH_MAX    = MODE_24H ? BCD_23 : BCD_12;
    localparam logic [7:0] HH_RST    = MODE_24H ? BCD_00 : BCD_12;
    localparam logic [7:0] AL_HH_RST = MODE_24H ? ALARM_HH_RST_24H : ALARM_HH_RST_12H;

    logic       load_acc, load_ok, load_go, tick;
    logic       ss_wrap, mm_wrap, hh_wrap;
    logic       pm_toggle;
    logic [7:0] mm_nxt, hh_nxt;
    logic       pm_nxt;

    logic       pm_q, pm_d;
    logic       day_wrap_q, day_wrap_d;
    logic       load_err_q, load_err_d;
    logic [7:0] al_hh_q, al_hh_d, al_mm_q, al_mm_d;
    logic       al_pm_q, al_pm_d, armed_q, armed_d;
    logic       hit_q, hit_d, flag_q, flag_d;

    assign load_ready = !reset;
    assign load_acc   = load_valid && load_ready;
    assign load_ok    = bcd_ok(load_ss) && (load_ss <= BCD_59) &&
                        bcd_ok(load_mm) && (load_mm <= BCD_59) &&
                        bcd_ok(load_hh) && (load_hh >= HH_MIN) && (load_hh <= HH_MAX);
    assign load_go    = load_acc && load_ok;
    // An accepted load (valid or not) swallows a same-cycle tick.
    assign tick       = ena && !load_acc;

    bcd_mod_counter #(.MIN(BCD_00), .MAX(BCD_59), .RST(BCD_00)) u_ss (
        .clk(clk), .reset(reset), .inc(tick), .load(load_go),
        .load_val(load_ss), .q(ss), .wrap(ss_wrap));

    bcd_mod_counter #(.MIN(BCD_00), .MAX(BCD_59), .RST(BCD_00)) u_mm (
        .clk(clk), .reset(reset), .inc(ss_wrap), .load(load_go),
        .load_val(load_mm), .q(mm), .wrap(mm_wrap));

    bcd_mod_counter #(.MIN(HH_MIN), .MAX(HH_MAX), .RST(HH_RST)) u_hh (
        .clk(clk), .reset(reset), .inc(mm_wrap), .load(load_go),
        .load_val(load_hh), .q(hh), .wrap(hh_wrap));

    // Post-tick time, so the alarm compares the value this tick produces.
    assign pm_toggle = !MODE_24H && mm_wrap && (hh == BCD_11);
    assign mm_nxt    = ss_wrap ? bcd_next(mm, BCD_00, BCD_59) : mm;
    assign hh_nxt    = mm_wrap ? bcd_next(hh, HH_MIN, HH_MAX) : hh;
    assign pm_nxt    = pm_q ^ pm_toggle;

    always_comb begin
        pm_d       = pm_q;
        if (load_go)
            pm_d = MODE_24H ? 1'b0 : load_pm;
        else if (pm_toggle)
            pm_d = !pm_q;
        day_wrap_d = MODE_24H ? hh_wrap : (pm_toggle && pm_q);
        load_err_d = load_acc && !load_ok;

        al_hh_d = al_hh_q;
        al_mm_d = al_mm_q;
        al_pm_d = al_pm_q;
        armed_d = armed_q;
        if (alarm_set) begin
            al_hh_d = alarm_hh;
            al_mm_d = alarm_mm;
            al_pm_d = MODE_24H ? 1'b0 : alarm_pm;
            armed_d = 1'b1;
        end
        hit_d  = ALARM_EN && armed_q && ss_wrap &&
                 (hh_nxt == al_hh_q) && (mm_nxt == al_mm_q) &&
                 (MODE_24H || (pm_nxt == al_pm_q));
        flag_d = ALARM_EN && (hit_d || (flag_q && !alarm_ack));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pm_q       <= 1'b0;
            day_wrap_q <= 1'b0;
            load_err_q <= 1'b0;
            al_hh_q    <= AL_HH_RST;
            al_mm_q    <= ALARM_MM_RST;
            al_pm_q    <= 1'b0;
            armed_q    <= 1'b0;
            hit_q      <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            pm_q       <= pm_d;
            day_wrap_q <= day_wrap_d;
            load_err_q <= load_err_d;
            al_hh_q    <= al_hh_d;
            al_mm_q    <= al_mm_d;
            al_pm_q    <= al_pm_d;
            armed_q    <= armed_d;
            hit_q      <= hit_d;
            flag_q     <= flag_d;
        end
    end

    assign pm         = pm_q;
    assign day_wrap   = day_wrap_q;
    assign load_err   = load_err_q;
    assign alarm_hit  = hit_q;
    assign alarm_flag = flag_q;

endmodule
